// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared opcode constants, fetch FSM encoding and fetch defaults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OP_PUSH_POP = 4'd7;
  localparam logic [3:0] OP_CALL     = 4'd11;
  localparam logic [3:0] OP_LD_ST_I  = 4'd12;

  localparam logic [7:0] DEF_RESET_PC = 8'h00;
  localparam logic [7:0] DEF_INT_VEC  = 8'h01;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_IMM   = 1'b1
  } fetch_state_t;

  // LDM/LDD/STD carry a trailing immediate byte.
  function automatic logic is_two_byte(input logic [3:0] opcode);
    return (opcode == OP_LD_ST_I);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module : if_id_reg
// Brief  : IF/ID pipeline register (IR, immediate, PC+1, valid, sf1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_reg #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_ir,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [ADDR_W-1:0] i_pc_plus1,
  input  logic              i_valid,
  input  logic              i_sf1,
  output logic [DATA_W-1:0] o_ir,
  output logic [DATA_W-1:0] o_imm,
  output logic [ADDR_W-1:0] o_pc_plus1,
  output logic              o_valid,
  output logic              o_sf1
);

  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_pc_plus1;
  logic              r_valid;
  logic              r_sf1;

  // Clear only kills the slot; payload fields keep their last contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir       <= '0;
      r_imm      <= '0;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
      r_sf1      <= 1'b0;
    end else if (i_clear) begin
      r_valid    <= 1'b0;
      r_sf1      <= 1'b0;
    end else if (i_load) begin
      r_ir       <= i_ir;
      r_imm      <= i_imm;
      r_pc_plus1 <= i_pc_plus1;
      r_valid    <= i_valid;
      r_sf1      <= i_sf1;
    end
  end

  assign o_ir       = r_ir;
  assign o_imm      = r_imm;
  assign o_pc_plus1 = r_pc_plus1;
  assign o_valid    = r_valid;
  assign o_sf1      = r_sf1;

endmodule

`default_nettype wire

// File: rtl/if_id_stage.sv
// ============================================================================
// Module : if_id_stage
// Brief  : Fetch stage with 1/2-byte instruction assembly, IF/ID register and
//          interrupt injection. Optional feature macro: FETCH_INTR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] INT_VEC  = ADDR_W'(DEF_INT_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              intr,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [ADDR_W-1:0] pc_plus1_out,
  output logic              valid_out,
  output logic              sf1
);

  logic [ADDR_W-1:0] r_pc;
  fetch_state_t      r_state;
  logic [DATA_W-1:0] r_hold_ir;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  fetch_state_t      w_state_nxt;
  logic [DATA_W-1:0] w_hold_nxt;
  logic              w_intr_req;
  logic              w_inject;
  logic              w_load;
  logic              w_clear;
  logic [DATA_W-1:0] w_ir_nxt;
  logic [DATA_W-1:0] w_imm_nxt;
  logic [ADDR_W-1:0] w_pp1_nxt;
  logic              w_valid_nxt;
  logic              w_sf1_nxt;
  logic              w_sf1_q;

  assign imem_addr = r_pc;
  assign w_pc_inc  = r_pc + 1'b1;

`ifdef FETCH_INTR_EN
  logic r_intr_pend;

  // A request arriving this very cycle is honoured at the current boundary.
  assign w_intr_req = r_intr_pend | intr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_intr_pend <= 1'b0;
    end else if (w_inject) begin
      r_intr_pend <= 1'b0;
    end else if (intr) begin
      r_intr_pend <= 1'b1;
    end
  end

  assign sf1 = w_sf1_q;
`else
  logic w_unused_intr;
  logic w_unused_sf1;

  assign w_intr_req    = 1'b0;
  assign w_unused_intr = intr;
  assign w_unused_sf1  = w_sf1_q;
  assign sf1           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_state   <= ST_FETCH;
      r_hold_ir <= '0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_state   <= w_state_nxt;
      r_hold_ir <= w_hold_nxt;
    end
  end

  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_ir;
    w_inject    = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_ir_nxt    = '0;
    w_imm_nxt   = '0;
    w_pp1_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_sf1_nxt   = 1'b0;

    if (br_taken) begin
      w_pc_nxt    = br_target;
      w_state_nxt = ST_FETCH;
      w_hold_nxt  = '0;
      w_clear     = 1'b1;
    end else if (!stall) begin
      case (r_state)
        ST_FETCH: begin
          if (w_intr_req) begin
            // Return address goes through IR; decode routes it to the RF.
            w_inject    = 1'b1;
            w_load      = 1'b1;
            w_ir_nxt    = DATA_W'(r_pc);
            w_pp1_nxt   = r_pc;
            w_valid_nxt = 1'b1;
            w_sf1_nxt   = 1'b1;
            w_pc_nxt    = INT_VEC;
          end else if (is_two_byte(imem_rdata[DATA_W-1 -: 4])) begin
            w_hold_nxt  = imem_rdata;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_IMM;
            w_clear     = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_ir_nxt    = imem_rdata;
            w_pp1_nxt   = w_pc_inc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
          end
        end
        ST_IMM: begin
          w_load      = 1'b1;
          w_ir_nxt    = r_hold_ir;
          w_imm_nxt   = imem_rdata;
          w_pp1_nxt   = w_pc_inc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_FETCH;
        end
        default: begin
          w_state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_ir       (w_ir_nxt),
    .i_imm      (w_imm_nxt),
    .i_pc_plus1 (w_pp1_nxt),
    .i_valid    (w_valid_nxt),
    .i_sf1      (w_sf1_nxt),
    .o_ir       (ir_out),
    .o_imm      (imm_out),
    .o_pc_plus1 (pc_plus1_out),
    .o_valid    (valid_out),
    .o_sf1      (w_sf1_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module : tb_if_id_stage
// Brief  : Self-checking bench for if_id_stage (vector table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       stall;
  logic       br_taken;
  logic [7:0] br_target;
  logic       intr;
  logic [7:0] ir_out;
  logic [7:0] imm_out;
  logic [7:0] pc_plus1_out;
  logic       valid_out;
  logic       sf1;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         st;
    bit         br;
    logic [7:0] bt;
    bit         in;
    bit         dchk;
    logic [7:0] ir;
    logic [7:0] imm;
    logic [7:0] pp1;
    bit         v;
    bit         sf;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl [19];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  if_id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .intr         (intr),
    .ir_out       (ir_out),
    .imm_out      (imm_out),
    .pc_plus1_out (pc_plus1_out),
    .valid_out    (valid_out),
    .sf1          (sf1)
  );

  function automatic vec_t mk(bit st, bit br, logic [7:0] bt, bit in, bit dchk,
                              logic [7:0] ir, logic [7:0] imm, logic [7:0] pp1,
                              bit v, bit sf, logic [7:0] pc);
    vec_t r;
    r.st = st; r.br = br; r.bt = bt; r.in = in; r.dchk = dchk;
    r.ir = ir; r.imm = imm; r.pp1 = pp1; r.v = v; r.sf = sf; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    stall = v.st; br_taken = v.br; br_target = v.bt; intr = v.in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, e.v});
    chk({tag, ".sf1"},   {7'd0, sf1},       {7'd0, e.sf});
    chk({tag, ".pc"},    imem_addr,         e.pc);
    if (e.dchk) begin
      chk({tag, ".ir"},  ir_out,       e.ir);
      chk({tag, ".imm"}, imm_out,      e.imm);
      chk({tag, ".pp1"}, pc_plus1_out, e.pp1);
    end
    stall = 1'b0; br_taken = 1'b0; intr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00; intr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ir",    ir_out,             8'h00);
    chk("rst.imm",   imm_out,            8'h00);
    chk("rst.pp1",   pc_plus1_out,       8'h00);
    chk("rst.valid", {7'd0, valid_out},  8'h00);
    chk("rst.sf1",   {7'd0, sf1},        8'h00);
    chk("rst.pc",    imem_addr,          8'h00);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h2D; mem[8'h01] = 8'hC0; mem[8'h02] = 8'h55;
    mem[8'h03] = 8'hC7; mem[8'h04] = 8'hAA; mem[8'h05] = 8'h31;
    mem[8'h06] = 8'hC3; mem[8'h07] = 8'h99; mem[8'h10] = 8'h77;
    mem[8'h40] = 8'h1A; mem[8'hFF] = 8'hCE;

    //             st br bt     in dchk ir     imm    pp1    v  sf pc
    tbl[0]  = mk(0, 0, 8'h00, 0, 1, 8'h2D, 8'h00, 8'h01, 1, 0, 8'h01);
    tbl[1]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h02);
    tbl[2]  = mk(0, 0, 8'h00, 0, 1, 8'hC0, 8'h55, 8'h03, 1, 0, 8'h03);
    tbl[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04);
    tbl[4]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04);
    tbl[5]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04);
    tbl[6]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04);
    tbl[7]  = mk(0, 0, 8'h00, 0, 1, 8'hC7, 8'hAA, 8'h05, 1, 0, 8'h05);
    tbl[8]  = mk(0, 0, 8'h00, 0, 1, 8'h31, 8'h00, 8'h06, 1, 0, 8'h06);
    tbl[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h07);
    tbl[10] = mk(1, 1, 8'h40, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h40);
    tbl[11] = mk(0, 0, 8'h00, 0, 1, 8'h1A, 8'h00, 8'h41, 1, 0, 8'h41);
    tbl[12] = mk(0, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFF);
    tbl[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00);
    tbl[14] = mk(0, 0, 8'h00, 0, 1, 8'hCE, 8'h2D, 8'h01, 1, 0, 8'h01);
    tbl[15] = mk(1, 0, 8'h00, 0, 1, 8'hCE, 8'h2D, 8'h01, 1, 0, 8'h01);
    tbl[16] = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h02);
    tbl[17] = mk(0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h10);
    tbl[18] = mk(0, 0, 8'h00, 0, 1, 8'h77, 8'h00, 8'h11, 1, 0, 8'h11);

    do_reset();
    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a two-byte instruction.
    do_reset();
    apply(mk(0, 0, 8'h00, 0, 1, 8'h2D, 8'h00, 8'h01, 1, 0, 8'h01), "rimm0");
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h02), "rimm1");
    do_reset();
    apply(mk(0, 0, 8'h00, 0, 1, 8'h2D, 8'h00, 8'h01, 1, 0, 8'h01), "rimm2");

    // Walk to PC=0x05 in FETCH, then exercise the interrupt input.
    do_reset();
    apply(mk(0, 0, 8'h00, 0, 1, 8'h2D, 8'h00, 8'h01, 1, 0, 8'h01), "walk0");
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h02), "walk1");
    apply(mk(0, 0, 8'h00, 0, 1, 8'hC0, 8'h55, 8'h03, 1, 0, 8'h03), "walk2");
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04), "walk3");
    apply(mk(0, 0, 8'h00, 0, 1, 8'hC7, 8'hAA, 8'h05, 1, 0, 8'h05), "walk4");
`ifdef FETCH_INTR_EN
    apply(mk(0, 0, 8'h00, 1, 1, 8'h05, 8'h00, 8'h05, 1, 1, 8'h01), "int0");
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h02), "int1");
    apply(mk(0, 0, 8'h00, 0, 1, 8'hC0, 8'h55, 8'h03, 1, 0, 8'h03), "int2");
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04), "iimm0");
    apply(mk(0, 0, 8'h00, 1, 1, 8'hC7, 8'hAA, 8'h05, 1, 0, 8'h05), "iimm1");
    apply(mk(0, 0, 8'h00, 0, 1, 8'h05, 8'h00, 8'h05, 1, 1, 8'h01), "iimm2");
    apply(mk(1, 0, 8'h00, 1, 1, 8'h05, 8'h00, 8'h05, 1, 1, 8'h01), "istl0");
    apply(mk(0, 0, 8'h00, 0, 1, 8'h01, 8'h00, 8'h01, 1, 1, 8'h01), "istl1");
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h02), "istl2");
`else
    apply(mk(0, 0, 8'h00, 1, 1, 8'h31, 8'h00, 8'h06, 1, 0, 8'h06), "noint0");
    apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h07), "noint1");
    apply(mk(0, 0, 8'h00, 1, 1, 8'hC3, 8'h99, 8'h08, 1, 0, 8'h08), "noint2");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
